// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular arithmetic blocks: FSM encoding,
// accumulator width for the default configuration, and modular negation.
package mod_arith_pkg;

    // Sequencer states shared by the reduction front end.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Plain constant encodings, usable where a bare logic vector is preferred.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    // Accumulator width for the default residue width (one guard bit above N).
    localparam int N_DEFAULT = 4;
    localparam int RW        = N_DEFAULT + 1;

    // (m - r) mod m for 0 <= r < m; zero maps to zero so m is never produced.
    function automatic int unsigned mod_neg(input int unsigned r, input int unsigned m);
        if (r == 0) begin
            return 0;
        end
        return m - r;
    endfunction

endpackage

// File: rtl/mod_fold_step.sv
// One MSB-first fold step: r_next = (2r + b) reduced once by M.
// Relies on r < M on entry, so 2r + b < 2M fits in N+1 bits and a single
// conditional subtract is enough.
module mod_fold_step #(
    parameter int N = 4,
    parameter int M = 13
) (
    input  logic [N:0] r,
    input  logic       b,
    output logic [N:0] r_next
);

    localparam logic [N:0] M_W = (N + 1)'(M);

    logic [N:0] t;

    // Double-and-add, then conditional subtract of the modulus.
    always_comb begin
        t      = {r[N-1:0], b};
        r_next = t;
        if (t >= M_W) begin
            r_next = t - M_W;
        end
    end

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential binary-to-residue converter. Accepts a W-bit operand, folds it
// into a residue mod M one bit per clock (MSB first), and optionally returns
// the modular negation. Valid/ready handshakes on both sides.
module mod_reduce_seq
    import mod_arith_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    parameter int M = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic         s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z
);

    localparam int ACC_W = N + 1;
    localparam int CW    = (W > 1) ? $clog2(W) : 1;

    logic [1:0]       state_reg;
    logic [W-1:0]     shift_reg;
    logic [ACC_W-1:0] r_reg;
    logic [CW-1:0]    cnt_reg;
    logic             s_reg;
    logic [N-1:0]     z_reg;

    logic [ACC_W-1:0] r_next;
    logic [N-1:0]     z_next;

    // The shift register presents the current bit at its MSB, which is the
    // same bit as x[cnt] because it shifts left once per fold.
    mod_fold_step #(
        .N (N),
        .M (M)
    ) u_fold (
        .r      (r_reg),
        .b      (shift_reg[W-1]),
        .r_next (r_next)
    );

    // Final result selection: plain residue or its modular negation.
    always_comb begin
        z_next = r_next[N-1:0];
        if (s_reg) begin
            z_next = N'(mod_neg(32'(r_next), 32'(M)));
        end
    end

    // Sequencer: capture in IDLE, fold W bits in RUN, hold result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            s_reg     <= 1'b0;
            z_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        shift_reg <= x;
                        s_reg     <= s;
                        r_reg     <= '0;
                        cnt_reg   <= CW'(W - 1);
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_reg     <= r_next;
                    shift_reg <= shift_reg << 1;
                    cnt_reg   <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        z_reg     <= z_next;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign z         = z_reg;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Scoreboard bench for mod_reduce_seq (N=4, W=8, M=13): the driver pushes the
// expected residue on every accepted operand; a monitor pops and compares on
// every output handshake.
module tb_mod_reduce_seq;

    localparam int N = 4;
    localparam int W = 8;
    localparam int M = 13;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic         s;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] z;

    int n_vec;
    int n_bad;
    int n_sent;
    int n_out;
    int exp_q[$];

    mod_reduce_seq #(
        .N (N),
        .W (W),
        .M (M)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs.
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int ref_z(input int xv, input int sv);
        int r;
        r = xv % M;
        if (sv != 0 && r != 0) r = M - r;
        return r;
    endfunction

    // Present an operand until the DUT takes it; push the expectation on accept.
    task automatic send(input int xv, input int sv, input int expz, input bit rnd);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        x        = W'(xv);
        s        = sv[0];
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        if (!acc) begin
            check("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(expz);
            n_sent++;
            $display("in  x=%0d s=%0d exp=%0d", xv, sv, expz);
        end
    endtask

    // Count edges until out_valid is seen high (sampled #1 after the edge).
    task automatic wait_valid(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) return;
        end
        check("valid_timeout", 0, 1);
    endtask

    int xs[7]   = '{200, 12, 0, 255, 13, 26, 7};
    int ss[7]   = '{1,   1,  1, 0,   0,  0,  0};
    int zs[7]   = '{8,   1,  0, 8,   0,  0,  7};

    initial begin
        int n;
        n_vec = 0; n_bad = 0; n_sent = 0; n_out = 0;
        rst = 1'b1; in_valid = 1'b0; x = '0; s = 1'b0; out_ready = 1'b1;

        // Monitor: compare on every output handshake.
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        $display("out z=%0d exp=%0d", z, e);
                        check("z", int'(z), e);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_z", int'(z), 0);
        rst = 1'b0;

        // Latency and ready-return timing.
        send(200, 0, 5, 1'b0);
        check("valid_after_accept", int'(out_valid), 0);
        wait_valid(n);
        check("latency", n, W);
        @(posedge clk);
        #1;
        check("ready_after_hs", int'(in_ready), 1);
        check("valid_after_hs", int'(out_valid), 0);
        check("z_hold_after_hs", int'(z), 5);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            send(xs[i], ss[i], zs[i], 1'b0);
            wait_valid(n);
            @(posedge clk);
            #1;
        end

        // Backpressure with a second operand waiting.
        out_ready = 1'b0;
        send(200, 0, 5, 1'b0);
        wait_valid(n);
        in_valid = 1'b1; x = W'(100); s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid), 1);
            check("stall_z", int'(z), 5);
            check("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(100, 0, 9, 1'b0);
        wait_valid(n);
        @(posedge clk);
        #1;
        check("z_hold_after_hs2", int'(z), 9);

        // Reset in the middle of RUN discards the operand.
        send(200, 0, 5, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_sent--;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_z", int'(z), 0);
        send(100, 0, 9, 1'b0);
        wait_valid(n);
        @(posedge clk);
        #1;

        // Random back-to-back with random output stalls.
        for (int i = 0; i < 1000; i++) begin
            int xv, sv;
            xv = int'($urandom_range(0, 255));
            sv = int'($urandom_range(0, 1));
            send(xv, sv, ref_z(xv, sv), 1'b1);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 100 && (exp_q.size() != 0 || out_valid); k++) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", exp_q.size(), 0);
        check("out_count", n_out, n_sent);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
